s2_bram_writer: RTL and testbench

S2_BRAM_WRITER -- requirements
Module: s2_bram_writer

---
 rtl/s2_pkg.sv | 19 +
 rtl/s2_relu_sat.sv | 33 +++
 rtl/s2_bram_writer.sv | 124 ++++++++++++
 tb/tb_s2_bram_writer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s2_pkg.sv
// s2_pkg: shared frame geometry and writer state encoding for the stage-2 BRAM writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package s2_pkg;

    localparam int FRAME_WORDS = 192;  // 8 rows x 8 cols x 3 channels
    localparam int N_CH        = 3;
    localparam int N_COL       = 8;
    localparam int N_ROW       = 8;
    localparam int ADDR_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FLUSH,
        DONE
    } wr_state_t;

endpackage

// File: rtl/s2_relu_sat.sv
// s2_relu_sat: arithmetic right shift, ReLU, then clip to an unsigned OUT_WIDTH word.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   din  - signed stage-1 result, IN_WIDTH bits
//   dout - unsigned BRAM word, OUT_WIDTH bits
// IN_WIDTH must exceed OUT_WIDTH so the clip bound is positive in the input domain.
module s2_relu_sat #(
    parameter int IN_WIDTH  = 36,
    parameter int OUT_WIDTH = 17,
    parameter int SHIFT     = 0
) (
    input  logic signed [IN_WIDTH-1:0] din,
    output logic [OUT_WIDTH-1:0]       dout
);

    localparam logic [IN_WIDTH-1:0] MAX_V = IN_WIDTH'({OUT_WIDTH{1'b1}});

    logic signed [IN_WIDTH-1:0] shifted;

    assign shifted = din >>> SHIFT;

    always_comb begin
        dout = shifted[OUT_WIDTH-1:0];
        if (shifted[IN_WIDTH-1]) begin
            dout = '0;
        end else if ($unsigned(shifted) > MAX_V) begin
            dout = '1;
        end
    end

endmodule

// File: rtl/s2_bram_writer.sv
// s2_bram_writer: writes a 192-word pixel-major frame into BRAM in channel-planar order.
// Latency: accepted word is written one cycle later; data_done pulses two cycles after the last word.
// Backpressure: in_ready is !s2_busy in IDLE, 1 in FILL, 0 in FLUSH/DONE.
//
// Ports:
//   clk, reset (async, active low)
//   in_valid/in_ready/in_data/in_last - stage-1 result stream
//   s2_busy                           - stage 2 still reading; holds off a new frame only
//   we/waddr/wdata                    - BRAM write port, address {cha,row,col}
//   data_done                         - one-cycle pulse after a full frame is written
//   frame_err                         - sticky: in_last disagreed with word position
module s2_bram_writer
    import s2_pkg::*;
#(
    parameter int IN_WIDTH  = 36,
    parameter int OUT_WIDTH = 17,
    parameter int SHIFT     = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic signed [IN_WIDTH-1:0] in_data,
    input  logic                       in_last,
    output logic                       in_ready,
    input  logic                       s2_busy,
    output logic                       we,
    output logic [ADDR_W-1:0]          waddr,
    output logic [OUT_WIDTH-1:0]       wdata,
    output logic                       data_done,
    output logic                       frame_err
);

    localparam logic [1:0] CHA_LAST = 2'(N_CH - 1);
    localparam logic [2:0] COL_LAST = 3'(N_COL - 1);
    localparam logic [2:0] ROW_LAST = 3'(N_ROW - 1);

    wr_state_t             state;
    logic [1:0]            cha;
    logic [2:0]            col;
    logic [2:0]            row;
    logic                  xfer;
    logic                  last_word;
    logic [OUT_WIDTH-1:0]  sat_data;

    s2_relu_sat #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_relu_sat (
        .din  (in_data),
        .dout (sat_data)
    );

    // s2_busy only blocks the start of a frame; once filling, the frame runs to completion.
    assign in_ready  = (state == IDLE) ? !s2_busy : (state == FILL);
    assign xfer      = in_valid && in_ready;
    assign last_word = (cha == CHA_LAST) && (col == COL_LAST) && (row == ROW_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cha       <= '0;
            col       <= '0;
            row       <= '0;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            data_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            we        <= 1'b0;
            data_done <= 1'b0;

            if (xfer) begin
                we    <= 1'b1;
                waddr <= {cha, row, col};
                wdata <= sat_data;
                // Framing is checked but never trusted: the frame always ends on word 191.
                if (in_last != last_word) begin
                    frame_err <= 1'b1;
                end
                if (cha == CHA_LAST) begin
                    cha <= '0;
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= row + 3'd1;
                    end else begin
                        col <= col + 3'd1;
                    end
                end else begin
                    cha <= cha + 2'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (xfer) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (xfer && last_word) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Final write is on the port this cycle; announce completion next cycle.
                    state     <= DONE;
                    data_done <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    cha   <= '0;
                    col   <= '0;
                    row   <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s2_bram_writer.sv
// tb_s2_bram_writer: randomized self-checking bench for s2_bram_writer.
// Latency: n/a.
// Backpressure: bench honours in_ready and can raise s2_busy mid-frame.
module tb_s2_bram_writer;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic signed [35:0] in_data;
    logic               in_last;
    logic               s2_busy;
    logic               in_ready, we, data_done, frame_err;
    logic [7:0]         waddr;
    logic [16:0]        wdata;
    logic               in_ready2, we2, data_done2, frame_err2;
    logic [7:0]         waddr2;
    logic [16:0]        wdata2;

    s2_bram_writer #(.IN_WIDTH(36), .OUT_WIDTH(17), .SHIFT(0)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .s2_busy(s2_busy), .we(we), .waddr(waddr), .wdata(wdata),
        .data_done(data_done), .frame_err(frame_err)
    );

    s2_bram_writer #(.IN_WIDTH(36), .OUT_WIDTH(17), .SHIFT(2)) u_dut_sh2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready2), .s2_busy(s2_busy), .we(we2), .waddr(waddr2), .wdata(wdata2),
        .data_done(data_done2), .frame_err(frame_err2)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc   = 0;
    int     err_cyc;
    longint frame_data [192];
    int     xfer_q [$];
    int     wr_cyc_q [$];
    int     done_q [$];
    int     wr_addr_q [$];
    longint wr_data_q [$];
    longint wr2_data_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Transfers seen at the falling edge complete on the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            if (in_valid && in_ready) xfer_q.push_back(cyc);
            if (we) begin
                wr_addr_q.push_back(int'(waddr));
                wr_data_q.push_back(longint'(wdata));
                wr_cyc_q.push_back(cyc);
            end
            if (we2) wr2_data_q.push_back(longint'(wdata2));
            if (data_done) done_q.push_back(cyc);
            if (frame_err && err_cyc < 0) err_cyc = cyc;
        end
    end

    // Reference: word k is pixel (row,col) channel cha; BRAM is channel-planar.
    function automatic int ref_addr(input int k);
        return (k % 3) * 64 + (k / 24) * 8 + (k / 3) % 8;
    endfunction

    function automatic longint ref_sat(input longint v, input int sh);
        longint s;
        s = v >>> sh;
        if (s < 0) return 0;
        if (s > 131071) return 131071;
        return s;
    endfunction

    function automatic longint rand_word();
        longint r;
        case ($urandom_range(3))
            0: return -longint'($urandom_range(1000));
            1: return longint'($urandom_range(131071));
            2: return longint'($urandom_range(140000, 125000));
            default: begin
                r = {$urandom(), $urandom()};
                return r >>> 28;
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        xfer_q.delete(); wr_cyc_q.delete(); done_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); wr2_data_q.delete();
        err_cyc = -1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic fill_random();
        for (int i = 0; i < 192; i++) frame_data[i] = rand_word();
    endtask

    task automatic drive_frame(input int nwords, input int pct, input int last_idx, input bit busy_mid);
        int  k;
        int  budget;
        bit  acc;
        k = 0;
        budget = 0;
        while (k < nwords && budget < 5000) begin
            in_valid = ($urandom_range(99) < pct);
            in_data  = frame_data[k][35:0];
            in_last  = (k == last_idx);
            if (busy_mid && k > 0) s2_busy = 1'($urandom_range(1));
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) k++;
            budget++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        s2_busy  = 1'b0;
        n_cmp++;
        if (k < nwords) begin
            n_bad++;
            $display("FAIL drive_timeout: accepted %0d words, wanted %0d", k, nwords);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; in_last = 1'b0; in_data = '0; s2_busy = 1'b0;
        tick(); tick();
        n_cmp++; if (we !== 1'b0)        begin n_bad++; $display("FAIL rst_we: got %b want 0", we); end
        n_cmp++; if (waddr !== 8'd0)     begin n_bad++; $display("FAIL rst_waddr: got %0d want 0", waddr); end
        n_cmp++; if (wdata !== 17'd0)    begin n_bad++; $display("FAIL rst_wdata: got %0d want 0", wdata); end
        n_cmp++; if (data_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", data_done); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", frame_err); end
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL rst_ready_idle: got %b want 1", in_ready); end
        s2_busy = 1'b1; #1;
        n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL rst_ready_busy: got %b want 0", in_ready); end
        in_valid = 1'b0; s2_busy = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_ramp();
        int bad;
        for (int i = 0; i < 192; i++) frame_data[i] = i;
        clear_logs();
        drive_frame(192, 100, 191, 1'b0);
        repeat (4) tick();
        n_cmp++; bad = 0;
        for (int i = 0; i < wr_addr_q.size() && i < 192; i++)
            if (wr_addr_q[i] != ref_addr(i) || wr_data_q[i] != ref_sat(frame_data[i], 0)) bad++;
        if (wr_addr_q.size() != 192 || bad != 0) begin
            n_bad++; $display("FAIL ramp_words: %0d writes %0d wrong, want 192 writes 0 wrong", wr_addr_q.size(), bad);
        end
        n_cmp++;
        if (!(wr_addr_q.size() == 192 && wr_addr_q[191] == 191 && wr_addr_q[1] == 64 && wr_addr_q[3] == 1)) begin
            n_bad++; $display("FAIL ramp_addr_pts: size %0d, want addr[1]=64 addr[3]=1 addr[191]=191", wr_addr_q.size());
        end
        n_cmp++; bad = 0;
        for (int i = 0; i < wr_cyc_q.size(); i++)
            if (i >= xfer_q.size() || wr_cyc_q[i] != xfer_q[i] + 1) bad++;
        if (bad != 0 || xfer_q.size() != 192) begin
            n_bad++; $display("FAIL ramp_latency: %0d late writes of %0d xfers, want 0 of 192", bad, xfer_q.size());
        end
        n_cmp++;
        if (!(xfer_q.size() == 192 && xfer_q[191] - xfer_q[0] == 191)) begin
            n_bad++; $display("FAIL ramp_b2b: %0d xfers not back-to-back, want 192 consecutive", xfer_q.size());
        end
        n_cmp++;
        if (!(done_q.size() == 1 && xfer_q.size() == 192 && done_q[0] == xfer_q[191] + 2)) begin
            n_bad++; $display("FAIL ramp_done: %0d pulses, want 1 pulse 2 cycles after last xfer", done_q.size());
        end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL ramp_err: got %b want 0", frame_err); end
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL ramp_idle_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_saturate();
        int     bad;
        longint exp5 [5];
        exp5 = '{0, 0, 131071, 131071, 131071};
        fill_random();
        frame_data[0] = -5; frame_data[1] = 0; frame_data[2] = 131071;
        frame_data[3] = 131072; frame_data[4] = (64'sd1 <<< 35) - 1; frame_data[5] = 400;
        clear_logs();
        drive_frame(192, 100, 191, 1'b0);
        repeat (4) tick();
        n_cmp++; bad = 0;
        for (int i = 0; i < 5; i++) if (i >= wr_data_q.size() || wr_data_q[i] != exp5[i]) bad++;
        if (bad != 0) begin n_bad++; $display("FAIL sat_edges: %0d of 5 edge words wrong, want 0", bad); end
        n_cmp++;
        if (!(wr2_data_q.size() > 5 && wr2_data_q[5] == 100)) begin
            n_bad++; $display("FAIL sat_shift2: got %0d want 100", wr2_data_q.size() > 5 ? wr2_data_q[5] : -1);
        end
        n_cmp++; bad = 0;
        for (int i = 0; i < wr_data_q.size() && i < 192; i++)
            if (wr_addr_q[i] != ref_addr(i) || wr_data_q[i] != ref_sat(frame_data[i], 0)) bad++;
        if (wr_data_q.size() != 192 || bad != 0) begin
            n_bad++; $display("FAIL sat_words: %0d writes %0d wrong, want 192 writes 0 wrong", wr_data_q.size(), bad);
        end
        n_cmp++; bad = 0;
        for (int i = 0; i < wr2_data_q.size() && i < 192; i++)
            if (wr2_data_q[i] != ref_sat(frame_data[i], 2)) bad++;
        if (wr2_data_q.size() != 192 || bad != 0) begin
            n_bad++; $display("FAIL sat_words_sh2: %0d writes %0d wrong, want 192 writes 0 wrong", wr2_data_q.size(), bad);
        end
    endtask

    task automatic test_busy_gate();
        int bad;
        int drop_cyc;
        fill_random();
        clear_logs();
        s2_busy = 1'b1; in_valid = 1'b1; in_data = frame_data[0][35:0]; in_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL busy_ready c%0d: got %b want 0", i, in_ready); end
            tick();
        end
        n_cmp++;
        if (wr_addr_q.size() != 0 || xfer_q.size() != 0) begin
            n_bad++; $display("FAIL busy_no_we: %0d writes %0d xfers, want 0", wr_addr_q.size(), xfer_q.size());
        end
        s2_busy = 1'b0; drop_cyc = cyc; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL busy_drop_ready: got %b want 1", in_ready); end
        drive_frame(192, 100, 191, 1'b1);
        repeat (4) tick();
        n_cmp++;
        if (!(xfer_q.size() > 0 && xfer_q[0] == drop_cyc)) begin
            n_bad++; $display("FAIL busy_first_xfer: %0d xfers, want first at cycle %0d", xfer_q.size(), drop_cyc);
        end
        n_cmp++; bad = 0;
        for (int i = 0; i < wr_addr_q.size() && i < 192; i++)
            if (wr_addr_q[i] != ref_addr(i) || wr_data_q[i] != ref_sat(frame_data[i], 0)) bad++;
        if (wr_addr_q.size() != 192 || bad != 0) begin
            n_bad++; $display("FAIL busy_words: %0d writes %0d wrong, want 192 writes 0 wrong", wr_addr_q.size(), bad);
        end
        n_cmp++;
        if (done_q.size() != 1) begin n_bad++; $display("FAIL busy_done: %0d pulses want 1", done_q.size()); end
    endtask

    task automatic test_valid_gaps();
        int bad;
        fill_random();
        clear_logs();
        drive_frame(192, 50, 191, 1'b0);
        repeat (4) tick();
        n_cmp++; bad = 0;
        for (int i = 0; i < wr_addr_q.size() && i < 192; i++)
            if (wr_addr_q[i] != ref_addr(i) || wr_data_q[i] != ref_sat(frame_data[i], 0)) bad++;
        if (wr_addr_q.size() != 192 || bad != 0) begin
            n_bad++; $display("FAIL gaps_words: %0d writes %0d wrong, want 192 writes 0 wrong", wr_addr_q.size(), bad);
        end
        n_cmp++; bad = 0;
        for (int i = 0; i < wr_cyc_q.size(); i++)
            if (i >= xfer_q.size() || wr_cyc_q[i] != xfer_q[i] + 1) bad++;
        if (bad != 0 || xfer_q.size() != 192) begin
            n_bad++; $display("FAIL gaps_latency: %0d late writes of %0d xfers, want 0 of 192", bad, xfer_q.size());
        end
        n_cmp++;
        if (!(done_q.size() == 1 && xfer_q.size() == 192 && done_q[0] == xfer_q[191] + 2)) begin
            n_bad++; $display("FAIL gaps_done: %0d pulses, want 1 pulse 2 cycles after last xfer", done_q.size());
        end
    endtask

    task automatic test_bad_last();
        fill_random();
        clear_logs();
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL badlast_pre: got %b want 0", frame_err); end
        drive_frame(192, 100, 100, 1'b0);
        repeat (4) tick();
        n_cmp++;
        if (!(xfer_q.size() == 192 && err_cyc == xfer_q[100] + 1)) begin
            n_bad++; $display("FAIL badlast_err_cyc: got %0d, want cycle after word 100", err_cyc);
        end
        n_cmp++;
        if (wr_addr_q.size() != 192 || done_q.size() != 1) begin
            n_bad++; $display("FAIL badlast_frame: %0d writes %0d done, want 192 and 1", wr_addr_q.size(), done_q.size());
        end
        clear_logs();
        drive_frame(192, 100, 191, 1'b0);
        repeat (4) tick();
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL badlast_sticky: got %b want 1", frame_err); end
        n_cmp++;
        if (wr_addr_q.size() != 192 || done_q.size() != 1) begin
            n_bad++; $display("FAIL badlast_next: %0d writes %0d done, want 192 and 1", wr_addr_q.size(), done_q.size());
        end
        pulse_reset();
        clear_logs();
        drive_frame(192, 100, -1, 1'b0);
        repeat (4) tick();
        n_cmp++;
        if (!(xfer_q.size() == 192 && err_cyc == xfer_q[191] + 1)) begin
            n_bad++; $display("FAIL nolast_err_cyc: got %0d, want cycle after word 191", err_cyc);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        fill_random();
        clear_logs();
        drive_frame(51, 100, -1, 1'b0);
        n_cmp++; if (we !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_we: got %b want 1", we); end
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if ({we, waddr, wdata, data_done, frame_err} !== '0) begin
            n_bad++; $display("FAIL rmid_clear: we=%b waddr=%0d wdata=%0d done=%b err=%b, want all 0",
                              we, waddr, wdata, data_done, frame_err);
        end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
        tick();
        reset = 1'b1;
        repeat (6) tick();
        n_cmp++; if (done_q.size() != 0) begin n_bad++; $display("FAIL rmid_no_done: %0d pulses want 0", done_q.size()); end
        clear_logs();
        drive_frame(192, 100, 191, 1'b0);
        repeat (4) tick();
        n_cmp++; bad = 0;
        for (int i = 0; i < wr_addr_q.size() && i < 192; i++)
            if (wr_addr_q[i] != ref_addr(i) || wr_data_q[i] != ref_sat(frame_data[i], 0)) bad++;
        if (wr_addr_q.size() != 192 || bad != 0) begin
            n_bad++; $display("FAIL rmid_next_words: %0d writes %0d wrong, want 192 writes 0 wrong", wr_addr_q.size(), bad);
        end
        n_cmp++;
        if (done_q.size() != 1) begin n_bad++; $display("FAIL rmid_next_done: %0d pulses want 1", done_q.size()); end
    endtask

    initial begin
        err_cyc = -1;
        test_reset();
        test_ramp();
        test_saturate();
        test_busy_gate();
        test_valid_gaps();
        test_bad_last();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
